// File: rtl/cobra_pkg.sv
// Cobra-1 bus controller shared types and defaults.
// Relocation and ROM wait state encodings live here.
package cobra_pkg;

  typedef enum logic {
    BOOT,
    RUN
  } reloc_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COUNT,
    W_HOLD
  } wait_state_e;

  localparam logic [15:0] COBRA_ROM_BASE   = 16'hC000;
  localparam logic [7:0]  COBRA_RELOC_PORT = 8'h1F;

  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cobra_bus_if.sv
// Z80 side and memory/IO side bus bundle for cobra_bus_ctrl.
// slave = the controller, master = CPU/memory environment.
interface cobra_bus_if #(
  parameter int ROM_AW = 11,
  parameter int BW     = 2
);
  logic [15:0]          cpu_a;
  logic [7:0]           cpu_do;
  logic                 mreq_n;
  logic                 iorq_n;
  logic                 rd_n;
  logic                 wr_n;
  logic                 m1_n;
  logic                 rfsh_n;
  logic [7:0]           ram_di;
  logic [7:0]           rom_di;
  logic [7:0]           io_di;
  logic [7:0]           cpu_di;
  logic                 wait_n;
  logic [15:0]          ram_a;
  logic [7:0]           ram_do;
  logic                 ram_w;
  logic [ROM_AW+BW-1:0] rom_a;
  logic [15:0]          io_a;

  modport slave (
    input  cpu_a, cpu_do,
    input  mreq_n, iorq_n, rd_n,
    input  wr_n, m1_n, rfsh_n,
    input  ram_di, rom_di, io_di,
    output cpu_di, wait_n,
    output ram_a, ram_do, ram_w,
    output rom_a, io_a
  );

  modport master (
    output cpu_a, cpu_do,
    output mreq_n, iorq_n, rd_n,
    output wr_n, m1_n, rfsh_n,
    output ram_di, rom_di, io_di,
    input  cpu_di, wait_n,
    input  ram_a, ram_do, ram_w,
    input  rom_a, io_a
  );
endinterface

// File: rtl/cobra_wait_gen.sv
// ROM wait-state generator: ROM_WAIT low cycles on wait_n per ROM read,
// then holds off until mreq_n rises so one access waits only once.
module cobra_wait_gen
  import cobra_pkg::*;
#(
  parameter int ROM_WAIT = 1
) (
  input  logic clk_cpu,
  input  logic rst_n,
  input  logic rom_hit,
  input  logic rd_n,
  input  logic mreq_n,
  output logic wait_n
);

  localparam logic [3:0] WLOAD =
    (ROM_WAIT > 0) ? 4'(ROM_WAIT - 1) : 4'd0;
  localparam logic WEN = (ROM_WAIT > 0);

  wait_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      W_IDLE: begin
        if (rom_hit & ~rd_n & WEN) begin
          state_d = W_COUNT;
          cnt_d   = WLOAD;
        end
      end
      W_COUNT: begin
        if (cnt_q == 4'd0) state_d = W_HOLD;
        else cnt_d = cnt_q - 4'd1;
      end
      W_HOLD: begin
        if (mreq_n) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      state_q <= W_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wait_n = (state_q != W_COUNT);

endmodule

// File: rtl/cobra_bus_ctrl.sv
// Cobra-1 Z80 bus controller: boot relocation, banked ROM window,
// ROM wait states and write protection of the ROM window.
module cobra_bus_ctrl
  import cobra_pkg::*;
#(
  parameter logic [15:0] ROM_BASE   = COBRA_ROM_BASE,
  parameter int          ROM_AW     = 11,
  parameter int          NUM_BANKS  = 4,
  parameter logic [15:0] RELOC_MASK = 16'hC000,
  parameter logic [7:0]  RELOC_PORT = COBRA_RELOC_PORT,
  parameter logic [7:0]  BANK_PORT  = 8'h1E,
  parameter int          ROM_WAIT   = 1,
  parameter int          AUTO_M1    = 0
) (
  input  logic                          clk_cpu,
  input  logic                          rst_n,
  cobra_bus_if.slave                    bus,
  output logic                          reloc_active,
  output logic [bank_w(NUM_BANKS)-1:0]  bank
);

  localparam int BW     = bank_w(NUM_BANKS);
  localparam int CW     = (AUTO_M1 > 0) ? $clog2(AUTO_M1 + 1) : 1;
  localparam int M1_LIM = (AUTO_M1 > 0) ? AUTO_M1 - 1 : 0;
  localparam logic M1EN = (AUTO_M1 > 0);

  reloc_state_e  reloc_q, reloc_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [CW-1:0] m1_cnt_q, m1_cnt_d;
  logic          m1_pend_q, m1_pend_d;
  logic [15:0]   eff_a;
  logic          rom_hit;
  logic          io_wr;
  logic          m1_done;

  assign reloc_active = (reloc_q == BOOT);
  assign bank         = bank_q;

  assign eff_a = reloc_active ? (bus.cpu_a | RELOC_MASK)
                              : bus.cpu_a;

  assign rom_hit = ~bus.mreq_n & bus.rfsh_n &
    (eff_a[15:ROM_AW] == ROM_BASE[15:ROM_AW]);

  assign io_wr = ~bus.iorq_n & ~bus.wr_n & bus.m1_n;

  assign bus.ram_a  = eff_a;
  assign bus.io_a   = eff_a;
  assign bus.ram_do = bus.cpu_do;
  assign bus.ram_w  = ~bus.mreq_n & ~bus.wr_n & ~rom_hit;
  assign bus.rom_a  = {bank_q, eff_a[ROM_AW-1:0]};

  always_comb begin
    bus.cpu_di = bus.ram_di;
    unique case (1'b1)
      bus.mreq_n: bus.cpu_di = bus.io_di;
      rom_hit:    bus.cpu_di = bus.rom_di;
      default:    bus.cpu_di = bus.ram_di;
    endcase
  end

  // a fetch is counted once, on the edge that sees m1_n back high
  always_comb begin
    m1_pend_d = m1_pend_q;
    m1_cnt_d  = m1_cnt_q;
    reloc_d   = reloc_q;
    bank_d    = bank_q;
    m1_done   = m1_pend_q & bus.m1_n & M1EN & reloc_active;
    if (~bus.m1_n & ~bus.mreq_n & ~bus.rd_n) m1_pend_d = 1'b1;
    else if (bus.m1_n) m1_pend_d = 1'b0;
    if (m1_done) begin
      m1_cnt_d = m1_cnt_q + CW'(1);
      if (m1_cnt_q == CW'(M1_LIM)) reloc_d = RUN;
    end
    if (io_wr && bus.cpu_a[7:0] == RELOC_PORT) reloc_d = RUN;
    if (io_wr && bus.cpu_a[7:0] == BANK_PORT)
      bank_d = bus.cpu_do[BW-1:0];
  end

  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      reloc_q   <= BOOT;
      bank_q    <= '0;
      m1_cnt_q  <= '0;
      m1_pend_q <= 1'b0;
    end else begin
      reloc_q   <= reloc_d;
      bank_q    <= bank_d;
      m1_cnt_q  <= m1_cnt_d;
      m1_pend_q <= m1_pend_d;
    end
  end

  cobra_wait_gen #(
    .ROM_WAIT (ROM_WAIT)
  ) u_wait (
    .clk_cpu (clk_cpu),
    .rst_n   (rst_n),
    .rom_hit (rom_hit),
    .rd_n    (bus.rd_n),
    .mreq_n  (bus.mreq_n),
    .wait_n  (bus.wait_n)
  );

endmodule
